// File: rtl/mux_arb4_if.sv
// Handshake bundle between a requester group and the mux_arb4 arbiter.
// Requests and last go in; the registered grant view comes back out.
interface mux_arb4_if;
    logic [3:0] req;
    logic       last;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       forced;

    modport master (
        output req, last,
        input  grant, sel, busy, forced
    );

    modport slave (
        input  req, last,
        output grant, sel, busy, forced
    );
endinterface

// File: rtl/mux_arb4.sv
// Four-way round-robin arbiter for a shared 4:1 mux path.
// Ownership is capped at MAX_HOLD cycles; timeouts pulse forced.
module mux_arb4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    mux_arb4_if.slave  bus
);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t     r_state, w_state_n;
    logic [3:0] r_grant, w_grant_n;
    logic [1:0] r_sel, w_sel_n;
    logic [1:0] r_ptr, w_ptr_n;
    logic [7:0] r_hold, w_hold_n;
    logic       r_busy;
    logic       r_forced, w_forced_n;

    logic       w_owner_req;
    logic       w_timeout;
    logic       w_release;
    logic [3:0] w_cand;
    logic       w_hit;
    logic [1:0] w_pick;
    logic [1:0] w_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= 4'b0000;
            r_sel    <= 2'd0;
            r_ptr    <= 2'd3;
            r_hold   <= 8'd0;
            r_busy   <= 1'b0;
            r_forced <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_grant  <= w_grant_n;
            r_sel    <= w_sel_n;
            r_ptr    <= w_ptr_n;
            r_hold   <= w_hold_n;
            r_busy   <= |w_grant_n;
            r_forced <= w_forced_n;
        end
    end

    always_comb begin
        w_owner_req = bus.req[r_sel];
        w_timeout   = (r_hold == 8'(MAX_HOLD));
        w_release   = (r_state == S_OWNED) &&
                      (!w_owner_req || bus.last || w_timeout);

        // An owner that signalled last does not compete again this edge
        w_cand = bus.req;
        if (r_state == S_OWNED && bus.last)
            w_cand[r_sel] = 1'b0;

        w_hit  = 1'b0;
        w_pick = r_ptr;
        w_idx  = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_hit && w_cand[w_idx]) begin
                w_hit  = 1'b1;
                w_pick = w_idx;
            end
        end

        w_state_n  = r_state;
        w_grant_n  = r_grant;
        w_sel_n    = r_sel;
        w_ptr_n    = r_ptr;
        w_hold_n   = r_hold;
        w_forced_n = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_grant_n = 4'b0000;
                if (w_hit) begin
                    w_state_n = S_OWNED;
                    w_grant_n = 4'b0001 << w_pick;
                    w_sel_n   = w_pick;
                    w_ptr_n   = w_pick;
                    w_hold_n  = 8'd1;
                end
            end
            S_OWNED: begin
                if (!w_release) begin
                    if (r_hold < 8'(MAX_HOLD))
                        w_hold_n = r_hold + 8'd1;
                end else begin
                    w_forced_n = w_timeout && w_owner_req && !bus.last;
                    if (w_hit) begin
                        w_grant_n = 4'b0001 << w_pick;
                        w_sel_n   = w_pick;
                        w_ptr_n   = w_pick;
                        w_hold_n  = 8'd1;
                    end else begin
                        w_state_n = S_IDLE;
                        w_grant_n = 4'b0000;
                        w_hold_n  = 8'd0;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_grant_n = 4'b0000;
            end
        endcase
    end

    assign bus.grant  = r_grant;
    assign bus.sel    = r_sel;
    assign bus.busy   = r_busy;
    assign bus.forced = r_forced;

endmodule

// File: tb/tb_mux_arb4.sv
// Randomized and directed checks of mux_arb4 against a
// cycle-level ownership model.
module tb_mux_arb4;

    localparam int MH = 8;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    mux_arb4_if bus ();

    mux_arb4 #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: owner is -1 when nobody holds the path
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_sel;
    int m_forced;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void pick(input logic [3:0] elig);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (elig[c]) begin
                m_owner = c;
                m_ptr   = c;
                m_sel   = c;
                m_hold  = 1;
                return;
            end
        end
    endfunction

    function automatic void model_step(input logic rst, input logic [3:0] rq,
                                       input logic lst);
        logic [3:0] elig;
        bit         still, to;
        if (rst) begin
            m_owner = -1; m_ptr = 3; m_hold = 0; m_sel = 0; m_forced = 0;
            return;
        end
        m_forced = 0;
        if (m_owner < 0) begin
            pick(rq);
            return;
        end
        still = rq[m_owner];
        to    = (m_hold == MH);
        if (!still || lst || to) begin
            m_forced = (to && still && !lst) ? 1 : 0;
            elig = rq;
            if (lst) elig[m_owner] = 1'b0;
            m_owner = -1;
            m_hold  = 0;
            pick(elig);
        end else if (m_hold < MH) begin
            m_hold++;
        end
    endfunction

    task automatic cyc(input logic rst, input logic [3:0] rq, input logic lst);
        logic [3:0] eg;
        reset    = rst;
        bus.req  = rq;
        bus.last = lst;
        @(posedge clk);
        model_step(rst, rq, lst);
        @(negedge clk);
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("sel", 32'(bus.sel), 32'(m_sel));
        chk("busy", 32'(bus.busy), 32'(eg != 4'b0000));
        chk("forced", 32'(bus.forced), 32'(m_forced));
        chk("onehot", 32'($onehot0(bus.grant)), 32'd1);
        chk("busy_or", 32'(bus.busy), 32'(|bus.grant));
        if (bus.busy)
            chk("sel_enc", 32'(bus.grant[bus.sel]), 32'd1);
    endtask

    initial begin
        logic [3:0] rq;
        n_chk = 0;
        n_err = 0;
        m_owner = -1; m_ptr = 3; m_hold = 0; m_sel = 0; m_forced = 0;
        reset = 1'b1; bus.req = 4'b0000; bus.last = 1'b0;

        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b1111, 1'b0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);

        // All four requesting: 8-cycle slots, rotating from 0
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 4'b1111, 1'b0);
            chk("rr_grant", 32'(bus.grant), 32'(4'b0001 << ((i / MH) % 4)));
            chk("rr_forced", 32'(bus.forced), 32'(i > 0 && (i % MH) == 0));
        end

        // Single-cycle request then idle, sel held
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0);
        chk("one_grant", 32'(bus.grant), 32'h4);
        chk("one_sel", 32'(bus.sel), 32'd2);
        cyc(1'b0, 4'b0000, 1'b0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_sel", 32'(bus.sel), 32'd2);

        // last from owner 1 hands straight to 3
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0010, 1'b0);
        chk("own1", 32'(bus.grant), 32'h2);
        cyc(1'b0, 4'b1010, 1'b1);
        chk("last_grant", 32'(bus.grant), 32'h8);
        chk("last_forced", 32'(bus.forced), 32'd0);

        // Lone requester is re-granted after each timeout
        cyc(1'b1, 4'b0000, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 4'b0100, 1'b0);
            chk("solo_grant", 32'(bus.grant), 32'h4);
            chk("solo_forced", 32'(bus.forced), 32'(i == 9 || i == 17));
        end

        // Reset during ownership by 3
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b1000, 1'b0);
        cyc(1'b0, 4'b1000, 1'b0);
        chk("own3", 32'(bus.grant), 32'h8);
        cyc(1'b1, 4'b1000, 1'b0);
        chk("midrst_grant", 32'(bus.grant), 32'd0);
        chk("midrst_sel", 32'(bus.sel), 32'd0);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("post_rst", 32'(bus.grant), 32'h1);

        // Sticky random requests so timeouts actually occur
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            rq = rq ^ 4'(($urandom_range(0, 7) == 0) ? $urandom : 0);
            cyc($urandom_range(0, 99) == 0, rq,
                $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
